// File: rtl/yuv422_to_rgb888.sv
// YUV 4:2:2 to RGB888 streaming decoder (BT.601 full range, fixed point).
// Even beats carry {Y0, U}. Odd beats carry {Y1, V}. Each odd beat yields two
// RGB pixels. They are staged in a two-entry pair buffer and drained P0 then P1.
// Sustained throughput is one pixel per cycle.
module yuv422_to_rgb888 #(
   parameter int unsigned FRAC = 8,
   parameter int unsigned K_RV = 359,
   parameter int unsigned K_GU = 88,
   parameter int unsigned K_GV = 183,
   parameter int unsigned K_BU = 454
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_sof,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] out_data
);

   localparam logic [0:0] PH_EVEN = 1'b0;
   localparam logic [0:0] PH_ODD  = 1'b1;

   // 20-bit signed arithmetic: largest product magnitude is 454 * 128 = 58112.
   localparam logic signed [19:0] KRV = 20'(K_RV);
   localparam logic signed [19:0] KGU = 20'(K_GU);
   localparam logic signed [19:0] KGV = 20'(K_GV);
   localparam logic signed [19:0] KBU = 20'(K_BU);
   localparam logic signed [19:0] RND = 20'(1 << (FRAC - 1));

   logic [0:0]  phase_q, phase_d;
   logic [7:0]  y0_q, y0_d;
   logic [7:0]  u_q, u_d;
   logic [23:0] p0_q, p0_d;
   logic [23:0] p1_q, p1_d;
   logic        p0_vld_q, p0_vld_d;
   logic        p1_vld_q, p1_vld_d;

   logic        accept;
   logic        pop;
   logic        odd_beat;
   logic        even_beat;

   logic signed [19:0] y0_s, y1_s, u_s, v_s;
   logic signed [19:0] r_off, g_off, b_off;
   logic [23:0]        pix0, pix1;

   // Clamp a signed channel sum into the 0..255 range.
   function automatic logic [7:0] sat8(input logic signed [19:0] x);
      logic [7:0] res;
      if (x < 20'sd0) begin
         res = 8'd0;
      end else if (x > 20'sd255) begin
         res = 8'hFF;
      end else begin
         res = x[7:0];
      end
      return res;
   endfunction

   // Handshake decode. An SOF beat always restarts a pair as its even half.
   always_comb begin
      if (phase_q == PH_EVEN) begin
         in_ready = 1'b1;
      end else begin
         // The odd half may only land when the pair buffer is free this cycle.
         in_ready = !p0_vld_q && (!p1_vld_q || out_ready);
      end
      accept    = in_valid && in_ready;
      pop       = out_valid && out_ready;
      odd_beat  = accept && (phase_q == PH_ODD) && !in_sof;
      even_beat = accept && !odd_beat;
   end

   // Colour conversion of the pending pair. u comes from the hold register, v from the odd beat.
   always_comb begin
      y0_s  = $signed({12'd0, y0_q});
      y1_s  = $signed({12'd0, in_data[15:8]});
      u_s   = $signed({12'd0, u_q}) - 20'sd128;
      v_s   = $signed({12'd0, in_data[7:0]}) - 20'sd128;
      r_off = (KRV * v_s + RND) >>> FRAC;
      g_off = (KGU * u_s + KGV * v_s + RND) >>> FRAC;
      b_off = (KBU * u_s + RND) >>> FRAC;
      pix0  = {sat8(y0_s + r_off), sat8(y0_s - g_off), sat8(y0_s + b_off)};
      pix1  = {sat8(y1_s + r_off), sat8(y1_s - g_off), sat8(y1_s + b_off)};
   end

   // Phase FSM and even-half hold registers next state.
   always_comb begin
      phase_d = phase_q;
      y0_d    = y0_q;
      u_d     = u_q;
      if (even_beat) begin
         y0_d    = in_data[15:8];
         u_d     = in_data[7:0];
         phase_d = PH_ODD;
      end else if (odd_beat) begin
         phase_d = PH_EVEN;
      end
   end

   // Pair buffer next state. A new pair may land in the same cycle P1 drains.
   always_comb begin
      p0_d     = p0_q;
      p1_d     = p1_q;
      p0_vld_d = p0_vld_q;
      p1_vld_d = p1_vld_q;
      if (odd_beat) begin
         p0_d     = pix0;
         p1_d     = pix1;
         p0_vld_d = 1'b1;
         p1_vld_d = 1'b1;
      end else if (pop) begin
         if (p0_vld_q) begin
            p0_vld_d = 1'b0;
         end else begin
            p1_vld_d = 1'b0;
         end
      end
   end

   // Phase and hold register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= PH_EVEN;
         y0_q    <= 8'd0;
         u_q     <= 8'd0;
      end else begin
         phase_q <= phase_d;
         y0_q    <= y0_d;
         u_q     <= u_d;
      end
   end

   // Pair buffer state. Reset drops any undrained pixels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_q     <= 24'd0;
         p1_q     <= 24'd0;
         p0_vld_q <= 1'b0;
         p1_vld_q <= 1'b0;
      end else begin
         p0_q     <= p0_d;
         p1_q     <= p1_d;
         p0_vld_q <= p0_vld_d;
         p1_vld_q <= p1_vld_d;
      end
   end

   // Output mux: P0 first, then P1. Both come straight from registers, so data holds under stall.
   always_comb begin
      out_valid = p0_vld_q || p1_vld_q;
      out_data  = p0_vld_q ? p0_q : p1_q;
   end

endmodule

// File: tb/tb_yuv422_to_rgb888.sv
// Directed, table-driven bench for yuv422_to_rgb888.
module tb_yuv422_to_rgb888;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_sof;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;

   int n_chk  = 0;
   int n_pass = 0;

   logic [23:0] got[$];
   logic        hold_active = 1'b0;
   logic [23:0] hold_data   = 24'd0;

   typedef struct {
      string       name;
      logic [7:0]  y0;
      logic [7:0]  u;
      logic [7:0]  y1;
      logic [7:0]  v;
      logic [23:0] p0;
      logic [23:0] p1;
   } vec_t;

   vec_t tbl[6];

   yuv422_to_rgb888 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: a pixel seen valid+ready at negedge transfers on the next posedge.
   always @(negedge clk) begin
      if (rst) begin
         hold_active = 1'b0;
      end else if (out_valid && out_ready) begin
         got.push_back(out_data);
         hold_active = 1'b0;
      end else if (out_valid) begin
         if (hold_active) check("stall_stable", {8'd0, out_data}, {8'd0, hold_data});
         hold_active = 1'b1;
         hold_data   = out_data;
      end else begin
         hold_active = 1'b0;
      end
   end

   // Offer one beat until accepted; called and returning at posedge + 1.
   task automatic send_beat(input logic [7:0] y, input logic [7:0] c, input logic sof);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_data  = {y, c};
      in_sof   = sof;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (!done) begin
         n_chk++;
         $display("FAIL beat_accept: in_ready stayed 0 for 64 cycles, required 1");
      end
   endtask

   task automatic wait_pixels(input int n);
      for (int i = 0; i < 100 && got.size() < n; i++) begin
         @(posedge clk);
         #1;
      end
      if (got.size() < n) begin
         n_chk++;
         $display("FAIL pixel_wait: got %0d pixels, required %0d", got.size(), n);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tbl[0] = '{"grey",    8'd128, 8'd128, 8'd128, 8'd128, 24'h808080, 24'h808080};
      tbl[1] = '{"redish",  8'd100, 8'd128, 8'd60,  8'd228, 24'hF01D64, 24'hC8003C};
      tbl[2] = '{"sat_hi",  8'd255, 8'd128, 8'd0,   8'd255, 24'hFFA4FF, 24'hB20000};
      tbl[3] = '{"sat_lo",  8'd0,   8'd128, 8'd0,   8'd0,   24'h005B00, 24'h005B00};
      tbl[4] = '{"corner",  8'd16,  8'd0,   8'd235, 8'd255, 24'hC20000, 24'hFFBC08};
      tbl[5] = '{"mixed",   8'd50,  8'd200, 8'd150, 8'd90,  24'h0034B2, 24'h6198FF};

      in_valid  = 1'b0;
      in_data   = 16'd0;
      in_sof    = 1'b0;
      out_ready = 1'b1;

      // Reset state.
      #1 rst = 1'b1;
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_data",  {8'd0, out_data},   32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(1);

      // Table vectors with free-flowing output.
      for (int i = 0; i < 6; i++) begin
         got.delete();
         send_beat(tbl[i].y0, tbl[i].u, 1'b0);
         check({tbl[i].name, "_no_early"}, {31'd0, out_valid}, 32'd0);
         send_beat(tbl[i].y1, tbl[i].v, 1'b0);
         check({tbl[i].name, "_lat_valid"}, {31'd0, out_valid}, 32'd1);
         check({tbl[i].name, "_lat_p0"}, {8'd0, out_data}, {8'd0, tbl[i].p0});
         wait_pixels(2);
         if (got.size() >= 2) begin
            check({tbl[i].name, "_p0"}, {8'd0, got[0]}, {8'd0, tbl[i].p0});
            check({tbl[i].name, "_p1"}, {8'd0, got[1]}, {8'd0, tbl[i].p1});
         end
         idle(2);
         check({tbl[i].name, "_count"}, got.size(), 32'd2);
      end

      // Back-pressure: three pairs offered while the output is stalled for 5 cycles.
      got.delete();
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               send_beat(tbl[k + 1].y0, tbl[k + 1].u, 1'b0);
               send_beat(tbl[k + 1].y1, tbl[k + 1].v, 1'b0);
            end
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", {8'd0, out_data}, {8'd0, tbl[1].p0});
            check("bp_no_xfer", got.size(), 32'd0);
            out_ready = 1'b1;
         end
      join
      wait_pixels(6);
      if (got.size() >= 6) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_pair%0d_p0", k), {8'd0, got[2 * k]},     {8'd0, tbl[k + 1].p0});
            check($sformatf("bp_pair%0d_p1", k), {8'd0, got[2 * k + 1]}, {8'd0, tbl[k + 1].p1});
         end
      end
      idle(3);
      check("bp_count", got.size(), 32'd6);

      // Reset mid-operation with a full pair buffer and a held even half.
      got.delete();
      out_ready = 1'b0;
      send_beat(8'd128, 8'd128, 1'b0);
      send_beat(8'd128, 8'd128, 1'b0);
      send_beat(8'd200, 8'd128, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      got.delete();
      send_beat(8'd60, 8'd128, 1'b0);
      send_beat(8'd60, 8'd128, 1'b0);
      wait_pixels(2);
      if (got.size() >= 2) begin
         check("post_rst_p0", {8'd0, got[0]}, 32'h003C3C3C);
         check("post_rst_p1", {8'd0, got[1]}, 32'h003C3C3C);
      end
      idle(4);
      check("post_rst_count", got.size(), 32'd2);

      // SOF resync: the lone even beat before SOF is discarded.
      got.delete();
      send_beat(8'd10, 8'd128, 1'b0);
      send_beat(8'd50, 8'd128, 1'b1);
      send_beat(8'd50, 8'd128, 1'b0);
      wait_pixels(2);
      if (got.size() >= 2) begin
         check("sof_p0", {8'd0, got[0]}, 32'h00323232);
         check("sof_p1", {8'd0, got[1]}, 32'h00323232);
      end
      idle(4);
      check("sof_count", got.size(), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/yuv422_to_rgb888.md
Name: yuv422_to_rgb888

Overview:
Streaming colour-space decoder. It converts a YUV 4:2:2 pixel stream (Y/U on even pixels, Y/V on odd pixels) back to packed RGB888 using BT.601 full-range fixed-point coefficients. It is the return path of the RGB888-to-YUV422 encoder and uses the same valid/ready stream discipline on both sides. Throughput is one pixel per cycle sustained.

Parameters:
FRAC, 8, fractional bits of the coefficients; rounding constant is 2^(FRAC-1)
K_RV, 359, V contribution to R (1.402 * 256)
K_GU, 88, U contribution to G (0.344 * 256)
K_GV, 183, V contribution to G (0.714 * 256)
K_BU, 454, U contribution to B (1.772 * 256)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts an input beat this cycle
in_data  in  16  {Y[15:8], C[7:0]}; C is U on even beats, V on odd beats
in_sof  in  1  start of frame; qualified by in_valid
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts the output pixel
out_data  out  24  {R[23:16], G[15:8], B[7:0]}

Behaviour:
- Transfer rules: an input beat is accepted when in_valid && in_ready; an output beat transfers when out_valid && out_ready.
- out_data holds stable while out_valid && !out_ready.
- Reset values: out_valid=0, out_data=0, in_ready=1, phase=EVEN, output pair buffer empty.
- Phase FSM:
  - EVEN: an accepted beat latches Y0 and U into the hold registers, then moves to ODD.
  - ODD: an accepted beat supplies Y1 and V, then computes both RGB pixels into a 2-entry pair buffer {P0, P1} and returns to EVEN.
- in_ready:
  - EVEN: always 1.
  - ODD: 1 only if the pair buffer is empty, or holds only P1 and P1 transfers this cycle.
- in_sof on an accepted beat forces that beat to be treated as EVEN, even if the FSM was in ODD. Any held even half is discarded and the FSM goes to ODD.
- Latency: P0 appears on out_valid on the cycle after the ODD beat is accepted. P1 follows on the first cycle after P0 transfers. Back-to-back pairs with out_ready=1 give out_valid high continuously.
- Arithmetic (signed, at least 18 bits):
  - u = U-128, v = V-128; rnd = 1<<(FRAC-1); >>> is arithmetic shift.
  - R = Y + ((K_RV*v + rnd) >>> FRAC)
  - G = Y - ((K_GU*u + K_GV*v + rnd) >>> FRAC)
  - B = Y + ((K_BU*u + rnd) >>> FRAC)
  - P0 uses Y0, P1 uses Y1; both pixels share the same u and v.
- Saturation: each channel is clamped to [0, 255] after summation; no wrap-around.
- Output drain order is P0 then P1. The buffer is never overwritten before P1 transfers (enforced by in_ready).
- Reset mid-operation: the held even half and any undrained pair are dropped, and out_valid drops to 0 asynchronously.

Test Plan:
- Reset: assert rst with a half pair pending -> out_valid=0 immediately; next beat is treated as EVEN; no stale pixel is emitted.
- Grey: beats {128,128} then {128,128} -> out 0x808080 twice; P0 valid one cycle after the second beat.
- Red-ish: {100,128},{60,228} -> P0 = R240 G29 B100 (0xF01D64); P1 = R200 G0 B60 (0xC8003C), where G is clamped from -11.
- Saturation: {255,128},{0,255} -> P0 R255 (clamped from 433) G164 B255; P1 = R178 G0 B0 (G clamped from -91). Then {0,128},{0,0} -> P0 = P1 = R0 G91 B0.
- Back-pressure: hold out_ready=0 for 5 cycles with 3 pairs offered -> in_ready=0 in ODD while the buffer is full; data is stable; releasing gives 6 pixels in order with no loss or duplicates.
- SOF resync: {10,128} then an SOF beat {50,128},{50,128} -> the first beat is discarded; exactly two pixels 0x323232 are output.
